// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div engine plus the HI/LO
// architectural registers, with mthi/mtlo writes and mfhi/mflo reads.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_C
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic [63:0] smul_s, umul_s;
  logic [31:0] abs_a_s, abs_b_s, sden_s, uden_s;
  logic [31:0] sq_mag_s, sr_mag_s, sq_s, sr_s, uq_s, ur_s;
  logic        div_by_zero_s, start_op_s;

  assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul_s = {32'd0, A} * {32'd0, B};

  // Signed division works on magnitudes, which keeps 0x80000000 / -1 well defined.
  assign div_by_zero_s = (B == 32'd0);
  assign abs_a_s  = A[31] ? (32'd0 - A) : A;
  assign abs_b_s  = B[31] ? (32'd0 - B) : B;
  assign sden_s   = div_by_zero_s ? 32'd1 : abs_b_s;
  assign uden_s   = div_by_zero_s ? 32'd1 : B;
  assign sq_mag_s = abs_a_s / sden_s;
  assign sr_mag_s = abs_a_s % sden_s;
  assign sq_s     = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sr_s     = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  assign uq_s     = A / uden_s;
  assign ur_s     = A % uden_s;

  assign start_op_s = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign Start      = start_op_s && (state_q == S_IDLE);
  assign Busy       = (state_q == S_BUSY);
  assign HI         = hi_q;
  assign LO         = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        case (MDUOp)
          OP_MULT: begin
            pend_hi_d = smul_s[63:32];
            pend_lo_d = smul_s[31:0];
            cnt_d     = MULT_CNT;
            state_d   = S_BUSY;
          end
          OP_MULTU: begin
            pend_hi_d = umul_s[63:32];
            pend_lo_d = umul_s[31:0];
            cnt_d     = MULT_CNT;
            state_d   = S_BUSY;
          end
          OP_DIV: begin
            pend_hi_d = div_by_zero_s ? hi_q : sr_s;
            pend_lo_d = div_by_zero_s ? lo_q : sq_s;
            cnt_d     = DIV_CNT;
            state_d   = S_BUSY;
          end
          OP_DIVU: begin
            pend_hi_d = div_by_zero_s ? hi_q : ur_s;
            pend_lo_d = div_by_zero_s ? lo_q : uq_s;
            cnt_d     = DIV_CNT;
            state_d   = S_BUSY;
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: begin
          end
        endcase
      end
      S_BUSY: begin
        // Every opcode is ignored while busy; the hazard unit already stalls them.
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    case (MDUOp)
      OP_MFHI: MDU_C = hi_q;
      OP_MFLO: MDU_C = lo_q;
      default: MDU_C = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, hand-written reset and
// move sequences, and randomized operations against a transaction-level model.
module tb_e_mdu;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDU_C;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDU_C(MDU_C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy_op;
    logic [31:0] busy_a;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of one mult/div, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (op)
      4'd1: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        return sp;
      end
      4'd2: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Issue one mult/div when idle, hold busy_op on the inputs while busy, check timing and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] bop, input logic [31:0] ba,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = (op == 4'd1 || op == 4'd2) ? MULT_C : DIV_C;
    MDUOp = op; A = a; B = b;
    #1;
    chk("start_issue", {31'd0, Start}, 32'd1);
    chk("busy_issue", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    MDUOp = bop; A = ba; B = $urandom();
    for (int i = 0; i < n; i++) begin
      #1;
      chk("busy_hold", {31'd0, Busy}, 32'd1);
      chk("start_locked", {31'd0, Start}, 32'd0);
      chk("hi_hold", HI, m_hi);
      chk("lo_hold", LO, m_lo);
      @(posedge clk); #1;
    end
    MDUOp = 4'd0;
    #1;
    chk("busy_done", {31'd0, Busy}, 32'd0);
    chk("hi_result", HI, eh);
    chk("lo_result", LO, el);
    MDUOp = 4'd7; #1;
    chk("mfhi", MDU_C, eh);
    MDUOp = 4'd8; #1;
    chk("mflo", MDU_C, el);
    MDUOp = 4'd0;
    m_hi = eh;
    m_lo = el;
  endtask

  // mthi/mtlo followed by the matching read in the next cycle.
  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    MDUOp = op; A = a; B = $urandom();
    @(posedge clk); #1;
    MDUOp = (op == 4'd5) ? 4'd7 : 4'd8;
    #1;
    chk("move_read", MDU_C, a);
    chk("move_busy", {31'd0, Busy}, 32'd0);
    if (op == 4'd5) m_hi = a; else m_lo = a;
    chk("move_other", (op == 4'd5) ? LO : HI, (op == 4'd5) ? m_lo : m_hi);
    MDUOp = 4'd0;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] res;

    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,          4'd0, 32'd0,      32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          4'd0, 32'd0,      32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{4'd4, 32'd7,         32'd0,          4'd0, 32'd0,      32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd2, 32'hFFFF_FFFF, 32'd2,          4'd5, 32'h1234,   32'h0000_0001, 32'hFFFF_FFFE};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  4'd1, 32'd5,      32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  4'd6, 32'h5555,   32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  4'd0, 32'd0,      32'h0000_0000, 32'h0000_0001};
    vecs[7] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  4'd3, 32'd9,      32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8] = '{4'd4, 32'hFFFF_FFFF, 32'd10,         4'd0, 32'd0,      32'h0000_0005, 32'h1999_9999};
    vecs[9] = '{4'd3, 32'h8000_0000, 32'd0,          4'd0, 32'd0,      32'h0000_0005, 32'h1999_9999};

    // Reset with an mthi pending on the inputs: reset must win.
    reset = 1'b1; MDUOp = 4'd5; A = 32'hFFFF_FFFF; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; MDUOp = 4'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_mduc", MDU_C, 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].busy_op, vecs[i].busy_a,
             vecs[i].exp_hi, vecs[i].exp_lo);

    move_to(4'd6, 32'hDEAD_BEEF);
    move_to(4'd5, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        move_to(($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6, $urandom());
      end else begin
        rop = 4'($urandom_range(1, 4));
        case ($urandom_range(0, 5))
          0: ra = 32'h8000_0000;
          1: ra = 32'($urandom_range(0, 100));
          default: ra = $urandom();
        endcase
        case ($urandom_range(0, 6))
          0: rb = 32'd0;
          1: rb = 32'hFFFF_FFFF;
          2: rb = 32'($urandom_range(1, 20));
          default: rb = $urandom();
        endcase
        res = ref_result(rop, ra, rb, m_hi, m_lo);
        run_op(rop, ra, rb, 4'($urandom_range(0, 15)), $urandom(), res[63:32], res[31:0]);
      end
    end

    // Make HI/LO non-zero, then reset in the 4th busy cycle of a div.
    move_to(4'd5, 32'h1111_2222);
    move_to(4'd6, 32'h3333_4444);
    MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    #1;
    chk("rstmid_start", {31'd0, Start}, 32'd1);
    @(posedge clk); #1;
    MDUOp = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_busy4", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, Busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rstmid_hi_after", HI, 32'd0);
      chk("rstmid_lo_after", LO, 32'd0);
      chk("rstmid_busy_after", {31'd0, Busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It also services mthi/mtlo/mfhi/mflo. Its read result travels down the pipeline as the M/W-stage MDU result, and its Busy output feeds the hazard unit's stall logic.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, Busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the posedge where it is high.
- MDUOp  input  4  operation of the instruction currently in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none.
- A  input  32  forwarded rs value in E.
- B  input  32  forwarded rt value in E.
- Start  output  1  combinational; high when MDUOp ∈ {1,2,3,4} and Busy=0.
- Busy  output  1  registered; high while a mult/div is in flight.
- HI  output  32  registered HI register.
- LO  output  32  registered LO register.
- MDU_C  output  32  combinational; HI when MDUOp=7, LO when MDUOp=8, otherwise 0.

## Operation
- State: HI, LO, Busy, cnt[3:0] (down-counter), pend_hi, pend_lo (result buffer).
- IDLE (Busy=0):
  - Start=1 (op 1–4): compute the result from A/B in the same cycle into pend_hi/pend_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and set Busy=1. HI/LO stay unchanged.
  - op 5 loads HI←A. op 6 loads LO←A. Either takes effect at the edge.
  - op 7/8/0 change no state.
- BUSY (Busy=1):
  - Each edge decrements cnt.
  - On the edge where cnt==1: HI←pend_hi, LO←pend_lo, Busy←0, cnt←0.
  - All MDUOp values are ignored while Busy=1, including mthi/mtlo and any new start. The hazard unit stalls such instructions in D, so this ignore rule is defensive only.
- Arithmetic:
  - mult: {HI,LO} = signed A × signed B, 64-bit.
  - multu: {HI,LO} = unsigned A × unsigned B.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Division by zero (B=0, div or divu): pend_hi/pend_lo are loaded with the current HI/LO. The Busy period still runs in full, and HI/LO are unchanged at its end.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- No flush input. An E-stage bubble arrives as MDUOp=0. An in-flight operation always completes.

## Timing
- Reset value of every register output: HI=0, LO=0, Busy=0. Internally cnt=0, pend_hi=0, pend_lo=0.
- Reset mid-operation aborts it: Busy=0 and HI/LO=0 after the reset edge. The pending result is discarded.
- Reset has priority over every MDUOp.
- Latency for a mult issued in cycle t (Start=1 in cycle t):
  - Busy=1 in cycles t+1…t+MULT_CYCLES.
  - Busy=0 and new HI/LO visible from cycle t+MULT_CYCLES+1.
  - Div behaves the same with DIV_CYCLES.
- mthi/mtlo in cycle t: new value visible in cycle t+1.
- mfhi/mflo: MDU_C reflects HI/LO in the same cycle, combinationally from the registers. There is no bypass of a same-cycle mthi/mtlo. Back-to-back mthi then mfhi reads the new value, since they are one cycle apart.
- Hazard-unit contract: stall any MDU-class instruction in D while (Start || Busy). e_mdu guarantees Busy is high the cycle after Start, with no gap.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then MDUOp=0 -> HI=0, LO=0, Busy=0, MDU_C=0 throughout.
- Signed mult: MDUOp=1, A=0xFFFFFFFE (−2), B=3 in cycle t, then MDUOp=0 -> Busy=1 for cycles t+1…t+5; in cycle t+6 Busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MDUOp=7 there gives MDU_C=0xFFFFFFFF.
- Signed div and divu: MDUOp=3, A=0xFFFFFFF9 (−7), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 -> after 10 Busy cycles HI/LO unchanged.
- Busy lockout: start multu A=0xFFFFFFFF, B=2; during Busy drive MDUOp=5, A=0x1234 -> ignored; final HI=0x00000001, LO=0xFFFFFFFE.
- mthi/mtlo/mflo: MDUOp=6, A=0xDEADBEEF, then MDUOp=8 next cycle -> MDU_C=0xDEADBEEF, Busy stays 0.
- Reset mid-op: start div A=100, B=7; assert reset in the 4th Busy cycle -> next cycle Busy=0, HI=0, LO=0; no later update to HI/LO.
